pkt_checker_mc: RTL and testbench

Multi-channel Avalon-ST framing monitor, the parametrised successor of the single-stream SOP/EOP checker. It taps any interleaved packet interface (e.g. parser→FPM or DMA paths) without loading it, since ready is an input only. It tracks framing independently per channel and checks packet length bounds and `empty` legality. It exposes saturating per-type error counters, a packet counter and a sticky first-error record for the debug CSR path.

---
 rtl/pkt_checker_pkg.sv | 18 +
 rtl/pkt_checker_mc_sat_counter.sv | 21 ++
 rtl/pkt_checker_mc.sv | 168 ++++++++++++++++
 tb/tb_pkt_checker_mc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pkt_checker_pkg.sv
// Shared types for the multi-channel Avalon-ST framing monitor.
package pkt_checker_pkg;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_NO_SOP  = 3'd1,
        ERR_DUP_SOP = 3'd2,
        ERR_LEN     = 3'd3,
        ERR_EMPTY   = 3'd4,
        ERR_CHAN    = 3'd5
    } err_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ch_state_t;

endpackage

// File: rtl/pkt_checker_mc_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pkt_checker_mc.sv
// Multi-channel passive framing monitor: per-channel SOP/EOP tracking,
// length and empty checks, saturating counters and a sticky first-error record.
module pkt_checker_mc
    import pkt_checker_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int EMPTY_W   = 6,
    parameter int MIN_BEATS = 1,
    parameter int MAX_BEATS = 24,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic               in_valid,
    input  logic               in_ready,
    input  logic [CH_W-1:0]    in_channel,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               clr,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   err_no_sop,
    output logic [CNT_W-1:0]   err_dup_sop,
    output logic [CNT_W-1:0]   err_len,
    output logic [CNT_W-1:0]   err_empty,
    output logic [CNT_W-1:0]   err_chan,
    output logic               err_any,
    output logic [2:0]         err_first_code,
    output logic [CH_W-1:0]    err_first_ch
);

    localparam int BCNT_W = $clog2(MAX_BEATS + 2);
    localparam int LEN_W  = BCNT_W + 1;
    localparam logic [BCNT_W-1:0] BCNT_SAT = BCNT_W'(MAX_BEATS + 1);
    localparam logic [LEN_W-1:0]  LEN_MIN  = LEN_W'(MIN_BEATS);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BEATS);
    localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(NUM_CH);

    ch_state_t          state [NUM_CH];
    logic [BCNT_W-1:0]  bcnt  [NUM_CH];

    ch_state_t          cur_state, next_state;
    logic [BCNT_W-1:0]  cur_bcnt, next_bcnt;
    logic               fire, chan_ok, done;
    logic [LEN_W-1:0]   len;
    logic               ev_pkt, ev_no_sop, ev_dup_sop, ev_len, ev_empty, ev_chan, ev_any;
    err_code_t          ev_code, first_code;

    assign fire    = in_valid & in_ready;
    assign chan_ok = ({1'b0, in_channel} < CH_LIMIT);

    // Fetch the addressed channel's context; out-of-range channels read as idle.
    always_comb begin
        cur_state = IDLE;
        cur_bcnt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_channel == CH_W'(i)) begin
                cur_state = state[i];
                cur_bcnt  = bcnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                bcnt[i]  <= '0;
            end
        end else if (fire && chan_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_channel == CH_W'(i)) begin
                    state[i] <= next_state;
                    bcnt[i]  <= next_bcnt;
                end
            end
        end
    end

    // A SOP always (re)starts a packet, whether the channel was idle or busy.
    always_comb begin
        next_state = cur_state;
        next_bcnt  = cur_bcnt;
        done       = 1'b0;
        len        = '0;
        if (fire && chan_ok) begin
            if (in_sop) begin
                if (in_eop) begin
                    next_state = IDLE;
                    next_bcnt  = '0;
                    done       = 1'b1;
                    len        = LEN_W'(1);
                end else begin
                    next_state = BUSY;
                    next_bcnt  = BCNT_W'(1);
                end
            end else if (cur_state == BUSY) begin
                if (in_eop) begin
                    next_state = IDLE;
                    next_bcnt  = '0;
                    done       = 1'b1;
                    len        = {1'b0, cur_bcnt} + LEN_W'(1);
                end else if (cur_bcnt != BCNT_SAT) begin
                    next_bcnt = cur_bcnt + BCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        ev_pkt     = 1'b0;
        ev_no_sop  = 1'b0;
        ev_dup_sop = 1'b0;
        ev_len     = 1'b0;
        ev_empty   = 1'b0;
        ev_chan    = 1'b0;
        if (fire) begin
            if (!chan_ok) begin
                ev_chan = 1'b1;
            end else begin
                ev_no_sop  = !in_sop && (cur_state == IDLE);
                ev_dup_sop = in_sop && (cur_state == BUSY);
                ev_empty   = !in_eop && (in_empty != '0);
                if (done) begin
                    if ((len >= LEN_MIN) && (len <= LEN_MAX)) begin
                        ev_pkt = 1'b1;
                    end else begin
                        ev_len = 1'b1;
                    end
                end
            end
        end
    end

    // Framing/length errors take precedence over the empty error on the same beat.
    always_comb begin
        ev_any = ev_no_sop | ev_dup_sop | ev_len | ev_empty | ev_chan;
        if (ev_no_sop)       ev_code = ERR_NO_SOP;
        else if (ev_dup_sop) ev_code = ERR_DUP_SOP;
        else if (ev_len)     ev_code = ERR_LEN;
        else if (ev_chan)    ev_code = ERR_CHAN;
        else if (ev_empty)   ev_code = ERR_EMPTY;
        else                 ev_code = ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_any      <= 1'b0;
            first_code   <= ERR_NONE;
            err_first_ch <= '0;
        end else if (!err_any && ev_any) begin
            err_any      <= 1'b1;
            first_code   <= ev_code;
            err_first_ch <= in_channel;
        end
    end

    assign err_first_code = first_code;

    sat_counter #(.W(CNT_W)) u_pkt_cnt     (.clk(clk), .rst(rst), .clr(clr), .inc(ev_pkt),     .cnt(pkt_cnt));
    sat_counter #(.W(CNT_W)) u_err_no_sop  (.clk(clk), .rst(rst), .clr(clr), .inc(ev_no_sop),  .cnt(err_no_sop));
    sat_counter #(.W(CNT_W)) u_err_dup_sop (.clk(clk), .rst(rst), .clr(clr), .inc(ev_dup_sop), .cnt(err_dup_sop));
    sat_counter #(.W(CNT_W)) u_err_len     (.clk(clk), .rst(rst), .clr(clr), .inc(ev_len),     .cnt(err_len));
    sat_counter #(.W(CNT_W)) u_err_empty   (.clk(clk), .rst(rst), .clr(clr), .inc(ev_empty),   .cnt(err_empty));
    sat_counter #(.W(CNT_W)) u_err_chan    (.clk(clk), .rst(rst), .clr(clr), .inc(ev_chan),    .cnt(err_chan));

endmodule

// File: tb/tb_pkt_checker_mc.sv
// Scenario bench for pkt_checker_mc; expectations are queued as stimulus is driven.
module tb_pkt_checker_mc;

    logic       clk = 1'b0;
    logic       rst, in_sop, in_eop, in_valid, in_ready, clr;
    logic [2:0] in_channel;
    logic [5:0] in_empty;
    logic [3:0] pkt_cnt, err_no_sop, err_dup_sop, err_len, err_empty, err_chan;
    logic       err_any;
    logic [2:0] err_first_code;
    logic [2:0] err_first_ch;

    typedef struct {
        int pkt, no_sop, dup_sop, len, empty, chan, any, code, ch;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pkt_checker_mc #(
        .NUM_CH(4), .CH_W(3), .EMPTY_W(6), .MIN_BEATS(1), .MAX_BEATS(24), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
        .in_ready(in_ready), .in_channel(in_channel), .in_empty(in_empty), .clr(clr),
        .pkt_cnt(pkt_cnt), .err_no_sop(err_no_sop), .err_dup_sop(err_dup_sop),
        .err_len(err_len), .err_empty(err_empty), .err_chan(err_chan), .err_any(err_any),
        .err_first_code(err_first_code), .err_first_ch(err_first_ch)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int p, int ns, int ds, int l, int em, int c, int a, int cd, int ch);
        exp_t e;
        e.pkt = p; e.no_sop = ns; e.dup_sop = ds; e.len = l; e.empty = em;
        e.chan = c; e.any = a; e.code = cd; e.ch = ch;
        return e;
    endfunction

    task automatic beat(input logic v, input logic r, input logic s, input logic e,
                        input int ch, input int emp);
        in_valid = v; in_ready = r; in_sop = s; in_eop = e;
        in_channel = 3'(ch); in_empty = 6'(emp);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        n_checks++; if (pkt_cnt !== 4'(e.pkt)) $display("[TB] FAIL reset_pkt: got %0d want %0d", pkt_cnt, e.pkt); else n_pass++;
        n_checks++; if ({err_no_sop, err_dup_sop, err_len, err_empty, err_chan} !== 20'd0) $display("[TB] FAIL reset_errs: got %h want 0", {err_no_sop, err_dup_sop, err_len, err_empty, err_chan}); else n_pass++;
        n_checks++; if ({err_any, err_first_code, err_first_ch} !== 7'(e.any)) $display("[TB] FAIL reset_first: got %b want 0", {err_any, err_first_code, err_first_ch}); else n_pass++;
    endtask

    task automatic test_legal_packet();
        exp_t e;
        pulse_clr();
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        beat(1, 1, 1, 0, 0, 0);
        beat(1, 1, 0, 0, 0, 0);
        beat(1, 1, 0, 1, 0, 5);
        e = sb.pop_front();
        n_checks++; if (pkt_cnt !== 4'(e.pkt)) $display("[TB] FAIL legal_pkt: got %0d want %0d", pkt_cnt, e.pkt); else n_pass++;
        n_checks++; if (err_empty !== 4'(e.empty)) $display("[TB] FAIL legal_empty: got %0d want %0d", err_empty, e.empty); else n_pass++;
        n_checks++; if (err_any !== 1'(e.any)) $display("[TB] FAIL legal_any: got %0d want %0d", err_any, e.any); else n_pass++;
    endtask

    task automatic test_interleave();
        exp_t e;
        pulse_clr();
        sb.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        beat(1, 1, 1, 0, 1, 0);
        beat(1, 1, 1, 0, 2, 0);
        beat(0, 1, 1, 1, 2, 0);
        beat(1, 1, 0, 0, 1, 0);
        beat(1, 0, 1, 0, 1, 0);
        beat(1, 1, 0, 1, 2, 0);
        beat(1, 0, 0, 0, 3, 0);
        beat(1, 1, 0, 0, 1, 0);
        beat(1, 0, 0, 1, 1, 0);
        beat(1, 1, 0, 1, 1, 0);
        e = sb.pop_front();
        n_checks++; if (pkt_cnt !== 4'(e.pkt)) $display("[TB] FAIL interleave_pkt: got %0d want %0d", pkt_cnt, e.pkt); else n_pass++;
        n_checks++; if (err_dup_sop !== 4'(e.dup_sop)) $display("[TB] FAIL interleave_dup: got %0d want %0d", err_dup_sop, e.dup_sop); else n_pass++;
        n_checks++; if (err_no_sop !== 4'(e.no_sop)) $display("[TB] FAIL interleave_nosop: got %0d want %0d", err_no_sop, e.no_sop); else n_pass++;
        n_checks++; if (err_any !== 1'(e.any)) $display("[TB] FAIL interleave_any: got %0d want %0d", err_any, e.any); else n_pass++;
    endtask

    task automatic test_framing_errors();
        exp_t e;
        pulse_clr();
        sb.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 3));
        beat(1, 1, 0, 0, 3, 0);
        beat(1, 1, 1, 0, 3, 0);
        beat(1, 1, 1, 0, 3, 0);
        beat(1, 1, 0, 1, 3, 0);
        e = sb.pop_front();
        n_checks++; if (err_no_sop !== 4'(e.no_sop)) $display("[TB] FAIL framing_nosop: got %0d want %0d", err_no_sop, e.no_sop); else n_pass++;
        n_checks++; if (err_dup_sop !== 4'(e.dup_sop)) $display("[TB] FAIL framing_dup: got %0d want %0d", err_dup_sop, e.dup_sop); else n_pass++;
        n_checks++; if (pkt_cnt !== 4'(e.pkt)) $display("[TB] FAIL framing_pkt: got %0d want %0d", pkt_cnt, e.pkt); else n_pass++;
        n_checks++; if (err_first_code !== 3'(e.code)) $display("[TB] FAIL framing_code: got %0d want %0d", err_first_code, e.code); else n_pass++;
        n_checks++; if (err_first_ch !== 3'(e.ch)) $display("[TB] FAIL framing_ch: got %0d want %0d", err_first_ch, e.ch); else n_pass++;
    endtask

    // 40-beat packet saturates bcnt (a wrapping counter would look legal), then 24, 25 and 1 beats.
    task automatic test_length();
        exp_t e;
        pulse_clr();
        sb.push_back(mk(2, 0, 0, 2, 0, 0, 1, 3, 0));
        beat(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 38; i++) beat(1, 1, 0, 0, 0, 0);
        beat(1, 1, 0, 1, 0, 0);
        beat(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 22; i++) beat(1, 1, 0, 0, 0, 0);
        beat(1, 1, 0, 1, 0, 0);
        beat(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 23; i++) beat(1, 1, 0, 0, 0, 0);
        beat(1, 1, 0, 1, 0, 0);
        beat(1, 1, 1, 1, 0, 0);
        e = sb.pop_front();
        n_checks++; if (err_len !== 4'(e.len)) $display("[TB] FAIL length_err: got %0d want %0d", err_len, e.len); else n_pass++;
        n_checks++; if (pkt_cnt !== 4'(e.pkt)) $display("[TB] FAIL length_pkt: got %0d want %0d", pkt_cnt, e.pkt); else n_pass++;
        n_checks++; if (err_first_code !== 3'(e.code)) $display("[TB] FAIL length_code: got %0d want %0d", err_first_code, e.code); else n_pass++;
    endtask

    task automatic test_empty_chan();
        exp_t e;
        pulse_clr();
        sb.push_back(mk(0, 0, 0, 0, 0, 1, 1, 5, 5));
        beat(1, 1, 0, 0, 5, 3);
        e = sb.pop_front();
        n_checks++; if (err_chan !== 4'(e.chan)) $display("[TB] FAIL chan_cnt: got %0d want %0d", err_chan, e.chan); else n_pass++;
        n_checks++; if (err_empty !== 4'(e.empty)) $display("[TB] FAIL chan_empty: got %0d want %0d", err_empty, e.empty); else n_pass++;
        n_checks++; if ({err_first_code, err_first_ch} !== {3'(e.code), 3'(e.ch)}) $display("[TB] FAIL chan_first: got %0d/%0d want %0d/%0d", err_first_code, err_first_ch, e.code, e.ch); else n_pass++;
        pulse_clr();
        sb.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4, 0));
        beat(1, 1, 1, 0, 0, 3);
        e = sb.pop_front();
        n_checks++; if (err_empty !== 4'(e.empty)) $display("[TB] FAIL empty_cnt: got %0d want %0d", err_empty, e.empty); else n_pass++;
        n_checks++; if (err_first_code !== 3'(e.code)) $display("[TB] FAIL empty_code: got %0d want %0d", err_first_code, e.code); else n_pass++;
        sb.push_back(mk(1, 0, 0, 0, 1, 0, 1, 4, 0));
        beat(1, 1, 0, 1, 0, 7);
        e = sb.pop_front();
        n_checks++; if ({pkt_cnt, err_empty} !== {4'(e.pkt), 4'(e.empty)}) $display("[TB] FAIL empty_eop: got pkt %0d empty %0d want %0d %0d", pkt_cnt, err_empty, e.pkt, e.empty); else n_pass++;
    endtask

    task automatic test_saturate_clr();
        exp_t e;
        pulse_clr();
        sb.push_back(mk(0, 15, 0, 0, 0, 0, 1, 1, 1));
        for (int i = 0; i < 20; i++) beat(1, 1, 0, 0, 1, 0);
        e = sb.pop_front();
        n_checks++; if (err_no_sop !== 4'(e.no_sop)) $display("[TB] FAIL sat_nosop: got %0d want %0d", err_no_sop, e.no_sop); else n_pass++;
        n_checks++; if (err_first_ch !== 3'(e.ch)) $display("[TB] FAIL sat_ch: got %0d want %0d", err_first_ch, e.ch); else n_pass++;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        clr = 1'b1;
        beat(1, 1, 0, 0, 1, 2);
        clr = 1'b0;
        e = sb.pop_front();
        n_checks++; if ({err_no_sop, err_empty, pkt_cnt} !== {4'(e.no_sop), 4'(e.empty), 4'(e.pkt)}) $display("[TB] FAIL clr_counts: got %h want 0", {err_no_sop, err_empty, pkt_cnt}); else n_pass++;
        n_checks++; if (err_any !== 1'(e.any)) $display("[TB] FAIL clr_any: got %0d want %0d", err_any, e.any); else n_pass++;
        sb.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 2));
        beat(1, 1, 0, 0, 2, 0);
        e = sb.pop_front();
        n_checks++; if ({err_any, err_no_sop, err_first_ch} !== {1'(e.any), 4'(e.no_sop), 3'(e.ch)}) $display("[TB] FAIL post_clr: got %b want %0d/%0d/%0d", {err_any, err_no_sop, err_first_ch}, e.any, e.no_sop, e.ch); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        exp_t e;
        beat(1, 1, 1, 0, 2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 2));
        beat(1, 1, 0, 1, 2, 0);
        e = sb.pop_front();
        n_checks++; if (err_no_sop !== 4'(e.no_sop)) $display("[TB] FAIL rstmid_nosop: got %0d want %0d", err_no_sop, e.no_sop); else n_pass++;
        n_checks++; if (pkt_cnt !== 4'(e.pkt)) $display("[TB] FAIL rstmid_pkt: got %0d want %0d", pkt_cnt, e.pkt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
        in_sop = 1'b0; in_eop = 1'b0; in_channel = '0; in_empty = '0;
        test_reset();
        test_legal_packet();
        test_interleave();
        test_framing_errors();
        test_length();
        test_empty_chan();
        test_saturate_clr();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
